// File: rtl/matmul_sequencer_if.sv
// Bundles the MATMUL sequencer's control, unified-buffer and systolic-array signals.
// master = the sequencer; slave = the control unit / UB / array side.
interface matmul_sequencer_if #(
  parameter int ADDR_WIDTH   = 16,
  parameter int BUFFER_WIDTH = 256,
  parameter int ARRAY_N      = 4
);
  localparam int SEL_W = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1;

  logic                    start;
  logic [ADDR_WIDTH-1:0]   a_base;
  logic [ADDR_WIDTH-1:0]   b_base;
  logic [ADDR_WIDTH-1:0]   c_base;
  logic [ADDR_WIDTH-1:0]   k_count;
  logic                    busy;
  logic                    done;
  logic                    ub_wr_en;
  logic [ADDR_WIDTH-1:0]   ub_addr;
  logic [BUFFER_WIDTH-1:0] ub_wdata;
  logic [BUFFER_WIDTH-1:0] ub_rdata;
  logic                    acc_clear;
  logic                    compute_enable;
  logic [BUFFER_WIDTH-1:0] a_row;
  logic [BUFFER_WIDTH-1:0] b_row;
  logic [SEL_W-1:0]        drain_sel;
  logic [BUFFER_WIDTH-1:0] result_row;

  modport master (
    input  start, a_base, b_base, c_base, k_count, ub_rdata, result_row,
    output busy, done, ub_wr_en, ub_addr, ub_wdata, acc_clear, compute_enable,
           a_row, b_row, drain_sel
  );

  modport slave (
    output start, a_base, b_base, c_base, k_count, ub_rdata, result_row,
    input  busy, done, ub_wr_en, ub_addr, ub_wdata, acc_clear, compute_enable,
           a_row, b_row, drain_sel
  );
endinterface

// File: rtl/matmul_sequencer.sv
// Runs one MATMUL: streams K A/B row pairs from the UB into the array, flushes it,
// then writes the ARRAY_N accumulator rows back to the UB starting at c_base.
module matmul_sequencer #(
  parameter int ADDR_WIDTH   = 16,
  parameter int BUFFER_WIDTH = 256,
  parameter int ARRAY_N      = 4,
  parameter int FLUSH_CYCLES = 6
) (
  input  logic                clk,
  input  logic                rst,
  matmul_sequencer_if.master  bus
);
  localparam int SEL_W      = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1;
  localparam int FC_W       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int FLUSH_LAST = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;

  // state | meaning: IDLE wait start, CLEAR zero accs, RD_A/RD_B fetch a pair,
  // FEED step array, FLUSH zero-operand steps, WB write C rows, DONE completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RD_A, S_RD_B, S_FEED, S_FLUSH, S_WB, S_DONE
  } state_t;

  state_t                  r_state, w_next;
  logic [ADDR_WIDTH-1:0]   r_a_ptr, r_b_ptr, r_c_ptr, r_k_left;
  logic [BUFFER_WIDTH-1:0] r_a_reg;
  logic [FC_W-1:0]         r_flush_cnt;
  logic [SEL_W-1:0]        r_row_cnt;
  logic                    w_flush_last;
  logic                    w_row_last;

  assign w_flush_last = (r_flush_cnt == FC_W'(FLUSH_LAST));
  assign w_row_last   = (r_row_cnt == SEL_W'(ARRAY_N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a_ptr     <= '0;
      r_b_ptr     <= '0;
      r_c_ptr     <= '0;
      r_k_left    <= '0;
      r_a_reg     <= '0;
      r_flush_cnt <= '0;
      r_row_cnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a_ptr  <= bus.a_base;
            r_b_ptr  <= bus.b_base;
            r_c_ptr  <= bus.c_base;
            r_k_left <= bus.k_count;
          end
        end
        S_CLEAR: r_row_cnt <= '0;
        S_RD_B:  r_a_reg <= bus.ub_rdata;
        S_FEED: begin
          r_a_ptr     <= r_a_ptr + ADDR_WIDTH'(1);
          r_b_ptr     <= r_b_ptr + ADDR_WIDTH'(1);
          r_k_left    <= r_k_left - ADDR_WIDTH'(1);
          r_flush_cnt <= '0;
          r_row_cnt   <= '0;
        end
        S_FLUSH: begin
          if (!w_flush_last) r_flush_cnt <= r_flush_cnt + FC_W'(1);
        end
        S_WB: begin
          if (!w_row_last) r_row_cnt <= r_row_cnt + SEL_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next             = r_state;
    bus.busy           = (r_state != S_IDLE);
    bus.done           = 1'b0;
    bus.ub_wr_en       = 1'b0;
    bus.ub_addr        = '0;
    bus.ub_wdata       = '0;
    bus.acc_clear      = 1'b0;
    bus.compute_enable = 1'b0;
    bus.a_row          = '0;
    bus.b_row          = '0;
    bus.drain_sel      = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        bus.acc_clear = 1'b1;
        w_next = (r_k_left != '0) ? S_RD_A : S_WB;
      end
      S_RD_A: begin
        bus.ub_addr = r_a_ptr;
        w_next = S_RD_B;
      end
      S_RD_B: begin
        bus.ub_addr = r_b_ptr;
        w_next = S_FEED;
      end
      S_FEED: begin
        bus.a_row          = r_a_reg;
        bus.b_row          = bus.ub_rdata;
        bus.compute_enable = 1'b1;
        if (r_k_left != ADDR_WIDTH'(1)) w_next = S_RD_A;
        else                            w_next = (FLUSH_CYCLES == 0) ? S_WB : S_FLUSH;
      end
      S_FLUSH: begin
        bus.compute_enable = 1'b1;
        if (w_flush_last) w_next = S_WB;
      end
      S_WB: begin
        bus.drain_sel = r_row_cnt;
        bus.ub_wr_en  = 1'b1;
        bus.ub_addr   = r_c_ptr + ADDR_WIDTH'(r_row_cnt);
        bus.ub_wdata  = bus.result_row;
        if (w_row_last) w_next = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end
endmodule
